// File: rtl/proj_pkg.sv
// Shared definitions for the MinHash projection path.
//   FM_BUFFER_SIZE : width of the FM-buffer index (matches proj_counter index)
//   HASH_WIDTH     : width of one hash sample
//   BOTTOM_K       : bottom-K signature length
//   topk_slot_t    : one working-list entry {valid, hash, index}
//   sweep_state_t  : bottom-K tracker sweep FSM states
package proj_pkg;

    localparam int unsigned FM_BUFFER_SIZE = 8;
    localparam int unsigned HASH_WIDTH     = 32;
    localparam int unsigned BOTTOM_K       = 4;

    typedef struct packed {
        logic                      valid;
        logic [HASH_WIDTH-1:0]     hash;
        logic [FM_BUFFER_SIZE-1:0] index;
    } topk_slot_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/proj_topk_insert.sv
// Combinational sorted insertion of one (hash, index) sample into a bottom-K list.
//   en           : sample is present this cycle; when low the list passes through
//   slot_valid/slot_hash/slot_index : current list, slot 0 holds the smallest hash
//   hash/index   : incoming sample
//   next_*_c     : list after insertion; the slot K-1 entry falls off when shifted
module proj_topk_insert
    import proj_pkg::*;
#(
    parameter int unsigned HW = HASH_WIDTH,
    parameter int unsigned IW = FM_BUFFER_SIZE,
    parameter int unsigned K  = BOTTOM_K
) (
    input  logic                 en,
    input  logic [K-1:0]         slot_valid,
    input  logic [K-1:0][HW-1:0] slot_hash,
    input  logic [K-1:0][IW-1:0] slot_index,
    input  logic [HW-1:0]        hash,
    input  logic [IW-1:0]        index,
    output logic [K-1:0]         next_valid_c,
    output logic [K-1:0][HW-1:0] next_hash_c,
    output logic [K-1:0][IW-1:0] next_index_c
);

    logic [K-1:0] gt;
    logic [K-1:0] ins_onehot;
    logic         seen_gt;
    logic         seen_ins;
    logic         carry_valid;
    logic [HW-1:0] carry_hash;
    logic [IW-1:0] carry_index;

    // Strictly-greater compare keeps equal hashes in arrival order; an empty slot
    // always accepts. The first accepting slot is the one-hot insertion point, and
    // every slot behind it takes its upper neighbour (carried through the loop).
    always_comb begin : insert_shift
        gt           = '0;
        ins_onehot   = '0;
        seen_gt      = 1'b0;
        seen_ins     = 1'b0;
        carry_valid  = 1'b0;
        carry_hash   = '0;
        carry_index  = '0;
        next_valid_c = slot_valid;
        next_hash_c  = slot_hash;
        next_index_c = slot_index;
        for (int i = 0; i < int'(K); i++) begin
            gt[i]         = ~slot_valid[i] | (slot_hash[i] > hash);
            ins_onehot[i] = en & gt[i] & ~seen_gt;
            if (ins_onehot[i]) begin
                next_valid_c[i] = 1'b1;
                next_hash_c[i]  = hash;
                next_index_c[i] = index;
            end else if (seen_ins) begin
                next_valid_c[i] = carry_valid;
                next_hash_c[i]  = carry_hash;
                next_index_c[i] = carry_index;
            end
            seen_gt     = seen_gt | gt[i];
            seen_ins    = seen_ins | ins_onehot[i];
            carry_valid = slot_valid[i];
            carry_hash  = slot_hash[i];
            carry_index = slot_index[i];
        end
    end

endmodule

// File: rtl/proj_bottomk_tracker.sv
// Keeps the K smallest hashes (with buffer indices) seen during one FM-buffer sweep
// and publishes the sorted signature through a valid/ready output register.
//   in_clk, in_rst_n : clock, async active-low reset
//   in_valid/in_hash/in_index/in_last : sample stream, in_last marks the sweep end
//   in_clear     : drop the working list and clear overflow (output register kept)
//   out_valid/out_ready : signature handshake
//   out_hashes/out_indices/out_count : signature, slot 0 in the LSBs, ascending
//   busy         : sweep in progress
//   overflow     : sticky, an unread signature was overwritten
module proj_bottomk_tracker
    import proj_pkg::*;
#(
    parameter int unsigned FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
    parameter int unsigned HASH_WIDTH     = proj_pkg::HASH_WIDTH,
    parameter int unsigned BOTTOM_K       = proj_pkg::BOTTOM_K
) (
    input  logic                               in_clk,
    input  logic                               in_rst_n,
    input  logic                               in_valid,
    input  logic [HASH_WIDTH-1:0]              in_hash,
    input  logic [FM_BUFFER_SIZE-1:0]          in_index,
    input  logic                               in_last,
    input  logic                               in_clear,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [BOTTOM_K*HASH_WIDTH-1:0]     out_hashes,
    output logic [BOTTOM_K*FM_BUFFER_SIZE-1:0] out_indices,
    output logic [$clog2(BOTTOM_K+1)-1:0]      out_count,
    output logic                               busy,
    output logic                               overflow
);

    localparam int unsigned HW = HASH_WIDTH;
    localparam int unsigned IW = FM_BUFFER_SIZE;
    localparam int unsigned K  = BOTTOM_K;
    localparam int unsigned CW = $clog2(BOTTOM_K + 1);

    sweep_state_t state_q, state_d;

    logic [K-1:0]         slot_valid_q;
    logic [K-1:0][HW-1:0] slot_hash_q;
    logic [K-1:0][IW-1:0] slot_index_q;

    logic [K-1:0]         ins_valid_c;
    logic [K-1:0][HW-1:0] ins_hash_c;
    logic [K-1:0][IW-1:0] ins_index_c;

    logic [K-1:0][HW-1:0] out_hash_q;
    logic [K-1:0][IW-1:0] out_index_q;
    logic [CW-1:0]        out_count_q;
    logic                 out_valid_q;
    logic                 overflow_q;
    logic                 busy_q;

    logic                 accept_c;
    logic                 sweep_end_c;
    logic [CW-1:0]        ins_count_c;

    // A clear in the same cycle as a sample drops the sample.
    assign accept_c    = in_valid & ~in_clear;
    assign sweep_end_c = accept_c & in_last;

    proj_topk_insert #(
        .HW (HW),
        .IW (IW),
        .K  (K)
    ) u_insert (
        .en           (accept_c),
        .slot_valid   (slot_valid_q),
        .slot_hash    (slot_hash_q),
        .slot_index   (slot_index_q),
        .hash         (in_hash),
        .index        (in_index),
        .next_valid_c (ins_valid_c),
        .next_hash_c  (ins_hash_c),
        .next_index_c (ins_index_c)
    );

    // Number of occupied slots in the list being published.
    always_comb begin : count_slots
        ins_count_c = '0;
        for (int i = 0; i < int'(K); i++) begin
            ins_count_c = ins_count_c + CW'(ins_valid_c[i]);
        end
    end

    // Sweep FSM next state.
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_c && !in_last)     state_d = ST_ACCUM;
            ST_ACCUM: if (in_clear || sweep_end_c)  state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_ACCUM);
        end
    end

    // Working list; emptied at sweep end so the next sweep can start right away.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            slot_valid_q <= '0;
            slot_hash_q  <= '1;
            slot_index_q <= '0;
        end else if (in_clear || sweep_end_c) begin
            slot_valid_q <= '0;
            slot_hash_q  <= '1;
            slot_index_q <= '0;
        end else begin
            slot_valid_q <= ins_valid_c;
            slot_hash_q  <= ins_hash_c;
            slot_index_q <= ins_index_c;
        end
    end

    // Output register, handshake and sticky overflow.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_hash_q  <= '0;
            out_index_q <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (sweep_end_c) begin
                out_hash_q  <= ins_hash_c;
                out_index_q <= ins_index_c;
                out_count_q <= ins_count_c;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (in_clear) begin
                overflow_q <= 1'b0;
            end else if (sweep_end_c && out_valid_q && !out_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_hashes  = out_hash_q;
    assign out_indices = out_index_q;
    assign out_count   = out_count_q;
    assign busy        = busy_q;
    assign overflow    = overflow_q;

endmodule
